// File: rtl/decam_key_sweep_ctrl.sv
// Key-sweep controller for a camouflaged netlist: applies each oracle test
// vector under every still-live candidate key and eliminates keys whose
// response disagrees with the oracle, stopping early once the key is unique.
module decam_key_sweep_ctrl #(
  parameter int PI_W   = 36,
  parameter int PO_W   = 7,
  parameter int KEY_W  = 2,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  vec_valid,
  output logic                  vec_ready,
  input  logic [PI_W-1:0]       vec_pi,
  input  logic [PO_W-1:0]       vec_po,
  input  logic                  vec_last,
  output logic [PI_W-1:0]       pi_out,
  output logic [KEY_W-1:0]      key_out,
  input  logic [PO_W-1:0]       po_in,
  output logic                  busy,
  output logic                  done,
  output logic [(2**KEY_W)-1:0] survivors,
  output logic [KEY_W-1:0]      key_value,
  output logic                  resolved,
  output logic                  no_key
);

  localparam int NK = 2**KEY_W;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [KEY_W-1:0] K_LAST = KEY_W'(NK - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VEC,
    APPLY,
    CHECK,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [NK-1:0]     surv_q, surv_d;
  logic [KEY_W-1:0]  k_q, k_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [PI_W-1:0]   pi_cap_q, pi_cap_d;
  logic [PO_W-1:0]   po_cap_q, po_cap_d;
  logic              last_q, last_d;
  logic [PI_W-1:0]   pi_out_q, pi_out_d;
  logic [KEY_W-1:0]  key_out_q, key_out_d;
  logic              done_q, done_d;
  logic              advance;
  logic [KEY_W-1:0]  k_next;
  logic [KEY_W-1:0]  lowest;

  function automatic logic [KEY_W:0] popcount(input logic [NK-1:0] v);
    logic [KEY_W:0] c;
    c = '0;
    for (int i = 0; i < NK; i++) c = c + (KEY_W+1)'(v[i]);
    return c;
  endfunction

  // State and datapath registers, all cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      surv_q    <= '1;
      k_q       <= '0;
      cnt_q     <= '0;
      pi_cap_q  <= '0;
      po_cap_q  <= '0;
      last_q    <= 1'b0;
      pi_out_q  <= '0;
      key_out_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      surv_q    <= surv_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      pi_cap_q  <= pi_cap_d;
      po_cap_q  <= po_cap_d;
      last_q    <= last_d;
      pi_out_q  <= pi_out_d;
      key_out_q <= key_out_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: the netlist drive is loaded only when stepping onto a live key,
  // so dead keys are skipped without disturbing pi_out/key_out
  always_comb begin
    state_d   = state_q;
    surv_d    = surv_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    pi_cap_d  = pi_cap_q;
    po_cap_d  = po_cap_q;
    last_d    = last_q;
    pi_out_d  = pi_out_q;
    key_out_d = key_out_q;
    done_d    = done_q;
    advance   = 1'b0;
    k_next    = k_q + KEY_W'(1);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          surv_d  = '1;
          k_d     = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
          state_d = WAIT_VEC;
        end
      end
      WAIT_VEC: begin
        if (vec_valid) begin
          pi_cap_d = vec_pi;
          po_cap_d = vec_po;
          last_d   = vec_last;
          k_d      = '0;
          cnt_d    = '0;
          state_d  = APPLY;
          if (surv_q[0]) begin
            pi_out_d  = vec_pi;
            key_out_d = '0;
          end
        end
      end
      APPLY: begin
        if (!surv_q[k_q]) begin
          advance = 1'b1;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CHECK: begin
        if (po_in != po_cap_q) surv_d[k_q] = 1'b0;
        advance = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (k_q == K_LAST) begin
        if (last_q || (popcount(surv_d) <= (KEY_W+1)'(1))) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = WAIT_VEC;
        end
      end else begin
        k_d     = k_next;
        state_d = APPLY;
        if (surv_d[k_next]) begin
          key_out_d = k_next;
          pi_out_d  = pi_cap_q;
        end
      end
    end
  end

  // Lowest-index survivor, used as the reported key
  always_comb begin
    lowest = '0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (surv_q[i]) lowest = KEY_W'(i);
    end
  end

  assign vec_ready = (state_q == WAIT_VEC);
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = done_q;
  assign pi_out    = pi_out_q;
  assign key_out   = key_out_q;
  assign survivors = surv_q;
  assign key_value = done_q ? lowest : '0;
  assign resolved  = done_q && (popcount(surv_q) == (KEY_W+1)'(1));
  assign no_key    = done_q && (surv_q == '0);

endmodule

// File: doc/decam_key_sweep_ctrl.md
DECAM_KEY_SWEEP_CTRL -- requirements
Module: decam_key_sweep_ctrl

Interface
REQ-001 Parameter: PI_W, 36, width of the primary-input pattern driven to the camouflaged c432 netlist.
REQ-002 Parameter: PO_W, 7, width of the primary-output response (N223,N329,N370,N421,N430,N431,N432).
REQ-003 Parameter: KEY_W, 2, camouflage key width (s_0,s_1); the candidate count is NK = 2**KEY_W.
REQ-004 Parameter: SETTLE, 2, cycles the key/pattern are held before sampling po_in; legal range 1..15.
REQ-005 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-006 Port: rst  input  1  asynchronous, active-high reset.
REQ-007 Port: start  input  1  single-cycle pulse that begins a sweep; honoured only in IDLE or DONE.
REQ-008 Port: vec_valid  input  1  test-vector/oracle pair is available.
REQ-009 Port: vec_ready  output  1  controller accepts the pair this cycle.
REQ-010 Port: vec_pi  input  PI_W  test pattern.
REQ-011 Port: vec_po  input  PO_W  oracle (unlocked-chip) response to vec_pi.
REQ-012 Port: vec_last  input  1  marks the final vector of the sweep.
REQ-013 Port: pi_out  output  PI_W  pattern driven to the camouflaged netlist.
REQ-014 Port: key_out  output  KEY_W  candidate key driven to the netlist key inputs.
REQ-015 Port: po_in  input  PO_W  netlist response, combinational from pi_out/key_out.
REQ-016 Port: busy  output  1  sweep in progress.
REQ-017 Port: done  output  1  result valid; held high until start or rst.
REQ-018 Port: survivors  output  NK  bit k set = key k is consistent with all vectors so far.
REQ-019 Port: key_value  output  KEY_W  index of the lowest set survivor bit; 0 if none.
REQ-020 Port: resolved  output  1  done and exactly one survivor.
REQ-021 Port: no_key  output  1  done and zero survivors (inconsistent oracle data).

Function
REQ-022 The FSM SHALL have the states IDLE, WAIT_VEC, APPLY, CHECK and DONE.
REQ-023 IDLE/DONE + start: survivors<=all ones, k<=0, done<=0, next state WAIT_VEC; busy=1 in every state except IDLE and DONE.
REQ-024 vec_ready SHALL be 1 only in WAIT_VEC; a transfer occurs on vec_valid&&vec_ready, capturing vec_pi, vec_po and vec_last, and sets k<=0 and next state APPLY.
REQ-025 APPLY with survivors[k]==0: skip in 1 cycle (k<=k+1, or go to end-of-vector when k==NK-1); no sampling.
REQ-026 APPLY with survivors[k]==1: drive key_out=k and pi_out=captured pattern, hold for exactly SETTLE cycles (4-bit counter), then go to CHECK.
REQ-027 CHECK (1 cycle): if po_in!=captured oracle, clear survivors[k]; key_out/pi_out stay stable through CHECK; then k<=k+1 and APPLY, or end-of-vector when k==NK-1.
REQ-028 End-of-vector: if the captured vec_last==1 or popcount(survivors)<=1, go to DONE (done<=1); otherwise go to WAIT_VEC.
REQ-029 Per-vector latency from handshake to next vec_ready = L*(SETTLE+1) + D cycles, where L = live candidates and D = dead candidates.
REQ-030 The early exit on popcount<=1 SHALL occur even with vectors pending; unconsumed vectors remain un-accepted.
REQ-031 start outside IDLE/DONE SHALL be ignored; vec_valid outside WAIT_VEC SHALL be ignored (not accepted).
REQ-032 In DONE, pi_out and key_out SHALL hold their last values; resolved, no_key and key_value SHALL be combinational from survivors and gated by done.
REQ-033 An ambiguous result (done, popcount>1) SHALL give resolved=0 and no_key=0, with key_value = lowest survivor.

Reset
REQ-034 rst SHALL force IDLE, survivors=all ones, k=0, counter=0, pi_out=0, key_out=0, vec_ready=0, busy=0 and done=0, immediately and asynchronously, including mid-sweep.
REQ-035 After rst deasserts, the controller SHALL require a new start; no partial sweep state is retained.

Verification
REQ-036 Golden key 2'b10 with 8 vectors where keys 00/01/11 mismatch on vectors 1,3,3 -> done after vector 3, survivors=0100, resolved=1, key_value=2, vectors 4..8 not accepted.
REQ-037 Timing with SETTLE=2, all 4 live, no mismatch -> exactly 12 cycles from handshake to next vec_ready; key_out sequence is 0,0,0,1,1,1,2,2,2,3,3,3.
REQ-038 Oracle contradicting all keys on vector 1 -> done, survivors=0000, no_key=1, resolved=0, key_value=0.
REQ-039 Two keys functionally equivalent on all 5 vectors, vec_last on vector 5 -> done, survivors=0011, resolved=0, no_key=0, key_value=0.
REQ-040 rst asserted during APPLY of vector 2, and start pulsed while busy -> immediate IDLE with all reset values; the start while busy has no effect on state.
REQ-041 vec_valid held with stalls while not in WAIT_VEC -> each vector is accepted exactly once; captured vec_pi is unaffected by input changes after the handshake.
